// File: rtl/instruction_sequencer_if.sv
// Program-ROM fetch bus between the instruction sequencer (master) and the ROM (slave).
// The ROM answers a read strobe with data exactly one cycle later.
interface instruction_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_read_enable;
  logic [31:0]           rom_data_in;

  modport master (
    output rom_address,
    output rom_read_enable,
    input  rom_data_in
  );

  modport slave (
    input  rom_address,
    input  rom_read_enable,
    output rom_data_in
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetches words from program ROM and presents each to the cpu for a fixed issue window.
// Optional illegal-opcode trap enabled by defining ILLEGAL_OPCODE_TRAP_EN.
module instruction_sequencer #(
  parameter int ADDR_WIDTH              = 10,
  parameter int MAX_MACHINE_CODE_LENGTH = 1023,
  parameter int ISSUE_INTERVAL          = 2
) (
  input  logic                    clock_in,
  input  logic                    reset_n_in,
  input  logic                    start_in,
  input  logic                    stall_in,
  instruction_sequencer_if.master rom_bus,
  output logic [31:0]             current_instruction,
  output logic                    instruction_valid,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   program_counter,
  output logic                    error_out,
  output logic [2:0]              fsm_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0]         LP_NOP  = 32'h0000_0008;
  localparam logic [ADDR_WIDTH:0] LP_MAX  = (ADDR_WIDTH+1)'(MAX_MACHINE_CODE_LENGTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [3:0]          LP_LAST = 4'(ISSUE_INTERVAL - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [3:0]            r_cnt;
  logic [31:0]           r_instr;
  logic [ADDR_WIDTH:0]   w_pc_inc;
  logic                  w_at_max;
  logic                  w_window_end;
  logic                  w_start_ok;
  logic                  w_zero_word;
  logic                  w_illegal;

  // pc is widened by one bit so the limit check can never wrap.
  assign w_pc_inc     = {1'b0, r_pc} + LP_ONE;
  assign w_at_max     = (w_pc_inc == LP_MAX);
  assign w_window_end = (r_cnt == LP_LAST);
  assign w_start_ok   = start_in && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_zero_word  = (rom_bus.rom_data_in == 32'h0000_0000);

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic r_error;

  always_comb begin
    w_illegal = 1'b1;
    case (rom_bus.rom_data_in[7:0])
      8'h00, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A: w_illegal = 1'b0;
      default:                                                       w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_error <= 1'b0;
    end else if (w_start_ok) begin
      r_error <= 1'b0;
    end else if ((r_state == ST_WAIT) && !w_zero_word && w_illegal) begin
      r_error <= 1'b1;
    end
  end

  assign error_out = r_error;
`else
  assign w_illegal = 1'b0;
  assign error_out = 1'b0;
`endif

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) r_state <= ST_IDLE;
    else             r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start_in) w_next_state = ST_FETCH;
      ST_FETCH:         w_next_state = ST_WAIT;
      ST_WAIT:          w_next_state = (w_zero_word || w_illegal) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        if (w_window_end && !stall_in) w_next_state = w_at_max ? ST_DONE : ST_FETCH;
      end
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: pc, issue-window counter and the latched instruction word.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_pc    <= '0;
      r_cnt   <= '0;
      r_instr <= LP_NOP;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start_in) r_pc <= '0;
        ST_WAIT: begin
          r_instr <= rom_bus.rom_data_in;
          r_cnt   <= '0;
        end
        ST_ISSUE: begin
          if (!w_window_end)             r_cnt <= r_cnt + 4'd1;
          else if (!stall_in && !w_at_max) r_pc <= w_pc_inc[ADDR_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registers so reset takes effect immediately.
  always_comb begin
    rom_bus.rom_address     = r_pc;
    rom_bus.rom_read_enable = (r_state == ST_FETCH);
    instruction_valid       = (r_state == ST_ISSUE);
    current_instruction     = (r_state == ST_ISSUE) ? r_instr : LP_NOP;
    busy                    = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_ISSUE);
    done                    = (r_state == ST_DONE);
    program_counter         = r_pc;
    fsm_state               = r_state;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, program ROM word-address width.
REQ-002 SHALL have parameter MAX_MACHINE_CODE_LENGTH, default 1023, maximum words fetched per run.
REQ-003 SHALL have parameter ISSUE_INTERVAL, default 2, minimum cycles each instruction is held on current_instruction (legal range 1..15).
REQ-004 SHALL have port clock_in  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_in  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start_in  input  1  level sampled each edge; begins a run from address 0 when idle or done.
REQ-007 SHALL have port stall_in  input  1  extends the current issue window while high.
REQ-008 SHALL have port rom_address  output  ADDR_WIDTH  registered word address to program ROM.
REQ-009 SHALL have port rom_read_enable  output  1  ROM read strobe; ROM returns data exactly one cycle later.
REQ-010 SHALL have port rom_data_in  input  32  ROM read data.
REQ-011 SHALL have port current_instruction  output  32  instruction word presented to the cpu.
REQ-012 SHALL have port instruction_valid  output  1  high on every cycle a fetched word is presented.
REQ-013 SHALL have port busy  output  1  high in FETCH, WAIT, ISSUE.
REQ-014 SHALL have port done  output  1  sticky run-complete flag, cleared by next accepted start.
REQ-015 SHALL have port program_counter  output  ADDR_WIDTH  index of word being fetched or issued.
REQ-016 SHALL have port error_out  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, ISSUE, DONE.
REQ-018 IDLE/DONE + start_in=1 SHALL clear pc, done, error_out and enter FETCH; start_in in other states SHALL be ignored.
REQ-019 FETCH SHALL drive rom_address=pc, rom_read_enable=1 for one cycle, then enter WAIT.
REQ-020 WAIT SHALL sample rom_data_in; word 32'h00000000 -> DONE, no issue; otherwise load current_instruction, set instruction_valid, enter ISSUE.
REQ-021 ISSUE SHALL hold the word for ISSUE_INTERVAL cycles, plus every cycle stall_in is high at window end; then pc increments, enter FETCH.
REQ-022 Outside ISSUE, current_instruction SHALL be 32'h00000008 (NOP) and instruction_valid 0, so the cpu never re-executes a word.
REQ-023 First instruction SHALL be valid on the third rising edge after start is sampled; steady-state period SHALL be 2+ISSUE_INTERVAL cycles absent stall.
REQ-024 When the incremented pc equals MAX_MACHINE_CODE_LENGTH, the sequencer SHALL enter DONE instead of FETCH; pc SHALL never wrap.
REQ-025 DONE SHALL assert done=1, busy=0, hold pc at the last value reached.
REQ-026 rom_read_enable SHALL be 0 in every state except FETCH.

Reset
REQ-027 reset_n_in low SHALL immediately force IDLE, pc=0, rom_address=0, rom_read_enable=0, current_instruction=32'h00000008, instruction_valid=0, busy=0, done=0, error_out=0.
REQ-028 Reset mid-run SHALL abandon the run; no further ROM reads until a new start after release.

Configuration
REQ-029 With ILLEGAL_OPCODE_TRAP_EN defined, WAIT SHALL check bits[7:0] against {00,01,03,04,05,06,08,09,0A}; mismatch sets error_out=1, enters DONE, word not issued.
REQ-030 Without ILLEGAL_OPCODE_TRAP_EN, every nonzero word SHALL be issued unchanged and error_out SHALL be tied 0.

Verification
REQ-031 ROM {0x00050109, 0x000A0209, 0x00000000}, start pulse -> two valid issues in order, each held 2 cycles, done=1 after 2 issues, third word never issued.
REQ-032 Same ROM, stall_in high 3 cycles during first ISSUE -> first word held 5 cycles, second word unaffected, total ROM reads 3.
REQ-033 ROM all 0x00000009, MAX_MACHINE_CODE_LENGTH=4 -> exactly 4 issues, done=1, program_counter=3, no read of address 4.
REQ-034 Reset asserted during second ISSUE -> outputs at reset values same cycle; restart re-issues word 0 first.
REQ-035 ROM {0x000000FF} with ILLEGAL_OPCODE_TRAP_EN -> error_out=1, done=1, instruction_valid never high; without macro -> 0x000000FF issued, error_out=0.
REQ-036 start_in held high through an entire run -> no restart while busy; new run begins on the cycle after done rises.
